// File: rtl/pluto_spi_frame_master.sv
`default_nettype none
// pluto_spi_frame_master -- 168-bit SPI frame master: shifts out the 21-byte command
// frame while capturing the 21-byte status frame into atomically updated outputs. Rev 1.0

module pluto_spi_frame_master #(
  parameter int CLKDIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] vel0,
  input  logic [15:0] vel1,
  input  logic [15:0] vel2,
  input  logic [15:0] vel3,
  input  logic [9:0]  dout_cmd,
  input  logic        wdt_en,
  input  logic [3:0]  dirtime,
  input  logic [3:0]  steptime,
  input  logic        spol,
  input  logic [1:0]  tap,
  output logic        busy,
  output logic        done,
  output logic [20:0] pos0,
  output logic [20:0] pos1,
  output logic [20:0] pos2,
  output logic [20:0] pos3,
  output logic [15:0] din,
  output logic        sync_err,
  output logic        SCK,
  output logic        SSEL,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [7:0] PH_LAST = 8'(CLKDIV - 1);
  localparam logic [7:0] TRAILER = 8'h14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  phase;
  logic [2:0]  bit_idx;
  logic [4:0]  byte_idx;

  logic [15:0] vel0_q, vel1_q, vel2_q, vel3_q;
  logic [9:0]  dout_q;
  logic        wdt_q, spol_q;
  logic [3:0]  dirtime_q, steptime_q;
  logic [1:0]  tap_q;

  logic [6:0]  rx_sr;
  logic [20:0] sh_pos0, sh_pos1, sh_pos2, sh_pos3;
  logic [15:0] sh_din;
  logic        sh_err;

  logic        phase_last;
  logic        last_bit;
  logic [2:0]  next_bit;
  logic [4:0]  next_byte;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_byte;
  logic        next_mosi;

  assign phase_last = (phase == PH_LAST);
  assign last_bit   = (byte_idx == 5'd20) && (bit_idx == 3'd7);
  assign next_bit   = bit_idx + 3'd1;
  assign next_byte  = byte_idx + {4'd0, (bit_idx == 3'd7)};
  assign rx_byte    = {rx_sr, MISO};
  // bits go out MSB first, so bit index n maps to byte bit 7-n
  assign next_mosi  = last_bit ? 1'b0 : tx_byte[~next_bit];

  always_comb begin
    tx_byte = 8'h00;
    case (next_byte)
      5'd0:    tx_byte = vel0_q[7:0];
      5'd1:    tx_byte = vel0_q[15:8];
      5'd2:    tx_byte = vel1_q[7:0];
      5'd3:    tx_byte = vel1_q[15:8];
      5'd4:    tx_byte = vel2_q[7:0];
      5'd5:    tx_byte = vel2_q[15:8];
      5'd6:    tx_byte = vel3_q[7:0];
      5'd7:    tx_byte = vel3_q[15:8];
      5'd8:    tx_byte = dout_q[7:0];
      5'd9:    tx_byte = {1'b0, wdt_q, 4'b0000, dout_q[9:8]};
      5'd10:   tx_byte = {spol_q, 3'b000, dirtime_q};
      5'd11:   tx_byte = {tap_q, 2'b00, steptime_q};
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= 8'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 5'd0;
      SCK        <= 1'b0;
      SSEL       <= 1'b1;
      MOSI       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pos0       <= 21'd0;
      pos1       <= 21'd0;
      pos2       <= 21'd0;
      pos3       <= 21'd0;
      din        <= 16'd0;
      sync_err   <= 1'b0;
      vel0_q     <= 16'd0;
      vel1_q     <= 16'd0;
      vel2_q     <= 16'd0;
      vel3_q     <= 16'd0;
      dout_q     <= 10'd0;
      wdt_q      <= 1'b0;
      spol_q     <= 1'b0;
      dirtime_q  <= 4'd0;
      steptime_q <= 4'd0;
      tap_q      <= 2'd0;
      rx_sr      <= 7'd0;
      sh_pos0    <= 21'd0;
      sh_pos1    <= 21'd0;
      sh_pos2    <= 21'd0;
      sh_pos3    <= 21'd0;
      sh_din     <= 16'd0;
      sh_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vel0_q     <= vel0;
            vel1_q     <= vel1;
            vel2_q     <= vel2;
            vel3_q     <= vel3;
            dout_q     <= dout_cmd;
            wdt_q      <= wdt_en;
            spol_q     <= spol;
            dirtime_q  <= dirtime;
            steptime_q <= steptime;
            tap_q      <= tap;
            state      <= ST_SETUP;
            phase      <= 8'd0;
            bit_idx    <= 3'd0;
            byte_idx   <= 5'd0;
            SSEL       <= 1'b0;
            SCK        <= 1'b0;
            MOSI       <= vel0[7];
            busy       <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (phase_last) begin
            phase <= 8'd0;
            state <= ST_HIGH;
            SCK   <= 1'b1;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_last) begin
            phase <= 8'd0;
            state <= ST_LOW;
            SCK   <= 1'b0;
            MOSI  <= next_mosi;
            rx_sr <= rx_byte[6:0];
            if (bit_idx == 3'd7) begin
              case (byte_idx)
                5'd0:    sh_pos0[7:0]   <= rx_byte;
                5'd1:    sh_pos0[15:8]  <= rx_byte;
                5'd2:    sh_pos0[20:16] <= rx_byte[4:0];
                5'd4:    sh_pos1[7:0]   <= rx_byte;
                5'd5:    sh_pos1[15:8]  <= rx_byte;
                5'd6:    sh_pos1[20:16] <= rx_byte[4:0];
                5'd8:    sh_pos2[7:0]   <= rx_byte;
                5'd9:    sh_pos2[15:8]  <= rx_byte;
                5'd10:   sh_pos2[20:16] <= rx_byte[4:0];
                5'd12:   sh_pos3[7:0]   <= rx_byte;
                5'd13:   sh_pos3[15:8]  <= rx_byte;
                5'd14:   sh_pos3[20:16] <= rx_byte[4:0];
                5'd16:   sh_din[7:0]    <= rx_byte;
                5'd17:   sh_din[15:8]   <= rx_byte;
                5'd20:   sh_err         <= (rx_byte != TRAILER);
                default: ;
              endcase
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_LOW: begin
          if (phase_last) begin
            phase <= 8'd0;
            if (last_bit) begin
              state <= ST_HOLD;
            end else begin
              state    <= ST_HIGH;
              SCK      <= 1'b1;
              bit_idx  <= next_bit;
              byte_idx <= next_byte;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_HOLD: begin
          if (phase_last) begin
            phase    <= 8'd0;
            state    <= ST_GAP;
            SSEL     <= 1'b1;
            done     <= 1'b1;
            pos0     <= sh_pos0;
            pos1     <= sh_pos1;
            pos2     <= sh_pos2;
            pos3     <= sh_pos3;
            din      <= sh_din;
            sync_err <= sh_err;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_GAP: begin
          if (phase_last) begin
            phase <= 8'd0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pluto_spi_frame_master.sv
`default_nettype none
// tb_pluto_spi_frame_master -- randomized frames against a slave model and a frame-level
// reference built from the byte map; includes cycle-exact timing and reset scenarios.

module tb_pluto_spi_frame_master;

  localparam int CLKDIV = 8;
  localparam int NBITS  = 168;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] vel0, vel1, vel2, vel3;
  logic [9:0]  dout_cmd;
  logic        wdt_en, spol;
  logic [3:0]  dirtime, steptime;
  logic [1:0]  tap;
  logic        busy, done, sync_err, SCK, SSEL, MOSI;
  logic        MISO = 1'b0;
  logic [20:0] pos0, pos1, pos2, pos3;
  logic [15:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  // slave-side frame images, byte 0 in the top 8 bits
  logic [167:0] rx_vec = '0;
  logic [167:0] mosi_vec = '0;
  int  rise_cnt = 0, total_rises = 0, miso_idx = 0;
  logic prev_sck = 1'b0, prev_ssel = 1'b1;

  logic [20:0] exp_pos [4];
  logic [15:0] exp_din;
  logic        exp_err;
  logic [20:0] last_pos0 = '0;
  logic [15:0] last_din = '0;

  pluto_spi_frame_master #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vel0(vel0), .vel1(vel1), .vel2(vel2), .vel3(vel3),
    .dout_cmd(dout_cmd), .wdt_en(wdt_en), .dirtime(dirtime), .steptime(steptime),
    .spol(spol), .tap(tap), .busy(busy), .done(done),
    .pos0(pos0), .pos1(pos1), .pos2(pos2), .pos3(pos3), .din(din), .sync_err(sync_err),
    .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // SPI slave model: presents MISO from SSEL fall, advances on SCK fall, captures MOSI on SCK rise
  always @(negedge clk) begin
    if (prev_ssel && !SSEL) begin
      rise_cnt <= 0;
      miso_idx <= 0;
      MISO     <= rx_vec[167];
    end else if (!SSEL && prev_sck && !SCK) begin
      if (miso_idx < NBITS - 1) MISO <= rx_vec[166 - miso_idx];
      miso_idx <= miso_idx + 1;
    end
    if (!SSEL && !prev_sck && SCK) begin
      if (rise_cnt < NBITS) mosi_vec[167 - rise_cnt] <= MOSI;
      rise_cnt <= rise_cnt + 1;
    end
    if (!prev_sck && SCK) total_rises <= total_rises + 1;
    prev_sck  <= SCK;
    prev_ssel <= SSEL;
  end

  task automatic rand_inputs();
    vel0 = 16'($urandom); vel1 = 16'($urandom); vel2 = 16'($urandom); vel3 = 16'($urandom);
    dout_cmd = 10'($urandom); wdt_en = 1'($urandom); spol = 1'($urandom);
    dirtime = 4'($urandom); steptime = 4'($urandom); tap = 2'($urandom);
  endtask

  // expected command frame from the byte map, using the current input values
  function automatic logic [167:0] build_tx();
    return {vel0[7:0], vel0[15:8], vel1[7:0], vel1[15:8], vel2[7:0], vel2[15:8],
            vel3[7:0], vel3[15:8], dout_cmd[7:0], {1'b0, wdt_en, 4'b0000, dout_cmd[9:8]},
            {spol, 3'b000, dirtime}, {tap, 2'b00, steptime}, 72'h0};
  endfunction

  // slave reply frame; discarded bytes and unused position bits carry random junk
  task automatic set_rx(input logic [20:0] p0, input logic [20:0] p1, input logic [20:0] p2,
                        input logic [20:0] p3, input logic [15:0] d, input logic [7:0] trl);
    logic [95:0] jk;
    jk = {$urandom, $urandom, $urandom};
    rx_vec = {p0[7:0], p0[15:8], {jk[2:0], p0[20:16]}, jk[15:8],
              p1[7:0], p1[15:8], {jk[18:16], p1[20:16]}, jk[31:24],
              p2[7:0], p2[15:8], {jk[34:32], p2[20:16]}, jk[47:40],
              p3[7:0], p3[15:8], {jk[50:48], p3[20:16]}, jk[63:56],
              d[7:0], d[15:8], jk[79:72], jk[87:80], trl};
    exp_pos[0] = p0; exp_pos[1] = p1; exp_pos[2] = p2; exp_pos[3] = p3;
    exp_din = d;
    exp_err = (trl != 8'h14);
  endtask

  task automatic run_frame(input string tag);
    logic [167:0] txe;
    int n;
    txe = build_tx();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || SSEL !== 1'b0) begin n_fail++; $display("FAIL %s accept: busy=%b SSEL=%b expected busy=1 SSEL=0", tag, busy, SSEL); end
    n_checks++; if (pos0 !== last_pos0 || din !== last_din) begin n_fail++; $display("FAIL %s hold_outputs: pos0=%h din=%h expected %h %h", tag, pos0, din, last_pos0, last_din); end
    rand_inputs();
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s done_timeout: no done within 3000 cycles", tag);
    end else begin
      if (pos0 !== exp_pos[0]) begin n_fail++; $display("FAIL %s pos0: got %h expected %h", tag, pos0, exp_pos[0]); end
      n_checks++; if (pos1 !== exp_pos[1]) begin n_fail++; $display("FAIL %s pos1: got %h expected %h", tag, pos1, exp_pos[1]); end
      n_checks++; if (pos2 !== exp_pos[2]) begin n_fail++; $display("FAIL %s pos2: got %h expected %h", tag, pos2, exp_pos[2]); end
      n_checks++; if (pos3 !== exp_pos[3]) begin n_fail++; $display("FAIL %s pos3: got %h expected %h", tag, pos3, exp_pos[3]); end
      n_checks++; if (din !== exp_din) begin n_fail++; $display("FAIL %s din: got %h expected %h", tag, din, exp_din); end
      n_checks++; if (sync_err !== exp_err) begin n_fail++; $display("FAIL %s sync_err: got %b expected %b", tag, sync_err, exp_err); end
      n_checks++; if (SSEL !== 1'b1) begin n_fail++; $display("FAIL %s ssel_at_done: got %b expected 1", tag, SSEL); end
      n_checks++; if (rise_cnt !== NBITS) begin n_fail++; $display("FAIL %s sck_rises: got %0d expected %0d", tag, rise_cnt, NBITS); end
      for (int k = 0; k < 21; k++) begin
        n_checks++;
        if (mosi_vec[167 - 8*k -: 8] !== txe[167 - 8*k -: 8]) begin
          n_fail++; $display("FAIL %s tx_byte%0d: got %h expected %h", tag, k, mosi_vec[167 - 8*k -: 8], txe[167 - 8*k -: 8]);
        end
      end
    end
    last_pos0 = exp_pos[0];
    last_din  = exp_din;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_release: got %b expected 0", tag, busy); end
  endtask

  task automatic test_reset();
    rand_inputs();
    reset = 1'b1; start = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (SSEL !== 1'b1 || SCK !== 1'b0 || MOSI !== 1'b0) begin n_fail++; $display("FAIL reset pins: SSEL=%b SCK=%b MOSI=%b expected 1 0 0", SSEL, SCK, MOSI); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset flags: busy=%b done=%b expected 0 0", busy, done); end
    n_checks++; if ({pos0, pos1, pos2, pos3, din, sync_err} !== '0) begin n_fail++; $display("FAIL reset rx_outputs: pos0=%h pos3=%h din=%h err=%b expected all 0", pos0, pos3, din, sync_err); end
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (total_rises !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset start_ignored: rises=%0d busy=%b expected 0 0", total_rises, busy); end
  endtask

  task automatic test_loopback();
    rand_inputs();
    set_rx(21'h12345, 21'($urandom), 21'($urandom), 21'h1FFFFF, 16'hA55A, 8'h14);
    run_frame("loopback");
  endtask

  task automatic test_tx_decode();
    int   idx  [6] = '{4, 5, 8, 9, 10, 11};
    logic [7:0] want [6] = '{8'hEF, 8'hBE, 8'hA5, 8'h43, 8'h83, 8'h89};
    rand_inputs();
    vel2 = 16'hBEEF; dout_cmd = 10'h3A5; wdt_en = 1'b1; spol = 1'b1;
    dirtime = 4'd3; tap = 2'd2; steptime = 4'd9;
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
    run_frame("tx_decode");
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mosi_vec[167 - 8*idx[i] -: 8] !== want[i]) begin
        n_fail++; $display("FAIL tx_decode b%0d: got %h expected %h", idx[i], mosi_vec[167 - 8*idx[i] -: 8], want[i]);
      end
    end
  endtask

  task automatic test_trailer();
    rand_inputs();
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h13);
    run_frame("trailer_bad");
    rand_inputs();
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
    run_frame("trailer_good");
  endtask

  task automatic test_random();
    logic [7:0] trl;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      trl = ($urandom_range(0, 1) == 0) ? 8'h14 : 8'($urandom);
      set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), trl);
      run_frame("random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
      run_frame("back_to_back");
    end
  endtask

  task automatic test_timing();
    int ssel_fall = -1, sck_rise = -1, done_at = -1, busy_fall = -1, dcount = 0, r0;
    logic ssel_done = 1'b0;
    rand_inputs();
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
    r0 = total_rises;
    start = 1'b1;
    for (int n = 1; n <= 2800; n++) begin
      @(negedge clk);
      if (n == 1)   start = 1'b0;
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
      if (ssel_fall < 0 && !SSEL) ssel_fall = n;
      if (sck_rise < 0 && SCK) sck_rise = n;
      if (done) begin
        dcount++;
        if (done_at < 0) begin done_at = n; ssel_done = SSEL; end
      end
      if (busy_fall < 0 && n > 1 && !busy) busy_fall = n;
      if (busy_fall > 0 && n >= busy_fall + 20) break;
    end
    n_checks++; if (ssel_fall !== 1) begin n_fail++; $display("FAIL timing ssel_fall: got %0d expected 1", ssel_fall); end
    n_checks++; if (sck_rise !== 1 + CLKDIV) begin n_fail++; $display("FAIL timing first_sck: got %0d expected %0d", sck_rise, 1 + CLKDIV); end
    n_checks++; if (done_at !== 1 + 338*CLKDIV || ssel_done !== 1'b1) begin n_fail++; $display("FAIL timing done: at %0d SSEL=%b expected %0d SSEL=1", done_at, ssel_done, 1 + 338*CLKDIV); end
    n_checks++; if (busy_fall !== 1 + 339*CLKDIV) begin n_fail++; $display("FAIL timing busy_fall: got %0d expected %0d", busy_fall, 1 + 339*CLKDIV); end
    n_checks++; if (dcount !== 1 || total_rises - r0 !== NBITS) begin n_fail++; $display("FAIL timing single_frame: done=%0d rises=%0d expected 1 %0d", dcount, total_rises - r0, NBITS); end
    n_checks++; if (pos2 !== exp_pos[2] || din !== exp_din) begin n_fail++; $display("FAIL timing data: pos2=%h din=%h expected %h %h", pos2, din, exp_pos[2], exp_din); end
    last_pos0 = exp_pos[0];
    last_din  = exp_din;
  endtask

  task automatic test_reset_midframe();
    rand_inputs();
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
    start = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (SSEL !== 1'b1 || SCK !== 1'b0 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset pins: SSEL=%b SCK=%b MOSI=%b busy=%b done=%b expected 1 0 0 0 0", SSEL, SCK, MOSI, busy, done); end
    n_checks++; if ({pos0, pos1, pos2, pos3, din, sync_err} !== '0) begin n_fail++; $display("FAIL midreset rx_cleared: pos0=%h din=%h err=%b expected 0", pos0, din, sync_err); end
    last_pos0 = '0;
    last_din  = '0;
    repeat (3) @(negedge clk);
    rand_inputs();
    set_rx(21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 16'($urandom), 8'h14);
    run_frame("after_reset");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_tx_decode();
    test_trailer();
    test_random();
    test_timing();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pluto_spi_frame_master.md
# pluto_spi_frame_master

SPI master that drives the stepper board's SPI slave from the FPGA side: it shifts out one complete 21-byte command frame (four 16-bit step velocities, 10 open-drain outputs, watchdog enable, step/dir timing, step polarity, tap), and simultaneously captures the returned frame (four 21-bit positions, 16 digital inputs, trailer byte). It sits between a servo-period sequencer (pulses `start` once per period) and the physical SCK/SSEL/MOSI/MISO pins, and is used both as a host bridge and as the slave's verification driver.

## Interface
- `CLKDIV`, 8, SCK half-period in `clk` cycles; legal range 4..255, because the slave runs a 3-stage synchronizer on SCK/SSEL.
- `clk` input 1, system clock; all logic on its rising edge.
- `reset` input 1, synchronous, active-high.
- `start` input 1, one-cycle request; accepted only when `busy`=0.
- `vel0`..`vel3` input 16 each, step velocities.
- `dout_cmd` input 10, output-pin states.
- `wdt_en` input 1, watchdog enable bit.
- `dirtime`, `steptime` input 4 each, stepgen timing.
- `spol` input 1, step polarity.
- `tap` input 2, stepgen tap select.
- `busy` output 1, high from accept until the inter-frame gap ends.
- `done` output 1, one-cycle pulse when the receive outputs update.
- `pos0`..`pos3` output 21 each, received positions.
- `din` output 16, received digital inputs.
- `sync_err` output 1, trailer byte of the last frame was not 0x14.
- `SCK`, `SSEL`, `MOSI` output 1 each; SSEL active low.
- `MISO` input 1.

## Operation
- All command inputs are latched into a 21-byte TX image in the cycle `start` is accepted; later input changes do not affect the frame in flight.
- TX bytes, each sent MSB first:
  - b0/b1: vel0 lo/hi; b2/b3: vel1; b4/b5: vel2; b6/b7: vel3.
  - b8: dout_cmd[7:0]; b9: {0, wdt_en, 0000, dout_cmd[9:8]}.
  - b10: {spol, 000, dirtime}; b11: {tap, 00, steptime}.
  - b12..b20: 0x00.
- RX bytes:
  - Positions: b0..b2 → pos0[7:0], [15:8], [20:16] (from b2[4:0]); b4..b6 → pos1; b8..b10 → pos2; b12..b14 → pos3.
  - b16/b17 → din lo/hi. b20 is compared against 0x14.
  - All other RX bytes are discarded.
- RX assembles in a shadow register. All of `pos*`, `din`, and `sync_err` update together in the `done` cycle; they are never partially updated.
- FSM states:
  - IDLE → SETUP on accepted `start`.
  - SETUP: SSEL=0, SCK=0, MOSI=b0 bit7, lasts CLKDIV cycles → HIGH.
  - HIGH: SCK=1 for CLKDIV cycles. MISO is sampled in the last HIGH cycle → LOW.
  - LOW: SCK=0 for CLKDIV cycles. MOSI moves to the next bit in the first LOW cycle. After bit 167 → HOLD, else → HIGH.
  - HOLD: SSEL=0, SCK=0 for CLKDIV cycles → GAP.
  - GAP: SSEL=1. `done` pulses in the first GAP cycle. Lasts CLKDIV cycles → IDLE.
- Counters: 3-bit bit index, 5-bit byte index (0..20), 8-bit phase counter. No wrap occurs within a frame.
- `start` while `busy`=1 is ignored. It is neither queued nor does it abort the frame.

## Timing
- Reset values: SCK=0, SSEL=1, MOSI=0, busy=0, done=0, pos0..3=0, din=0, sync_err=0, FSM=IDLE.
- Accept at edge E. From E+1: busy=1, SSEL=0.
- First SCK rise at E+1+CLKDIV.
- 168 bits × 2·CLKDIV cycles each.
- SSEL low for 338·CLKDIV cycles. For CLKDIV=8 this is 2704 cycles.
- `done` occurs in the first cycle SSEL=1. `busy` falls after 339·CLKDIV total cycles.
- Earliest next accept is in the first cycle `busy`=0.
- MOSI is stable for the whole HIGH phase. MISO is sampled CLKDIV−1 cycles after the SCK rise.
- Reset mid-frame: all outputs return to reset values on the next edge (SSEL rises immediately). Receive outputs are cleared. The slave may have latched partial velocities; the next full frame overwrites them.
- Reset and `start` asserted together: reset wins, and no frame starts.

## Test plan
- Reset value check: hold reset 5 cycles → SSEL=1, SCK=0, busy=0, and all receive outputs 0; with `start` asserted during reset, no SCK edge appears.
- Loopback against a slave model returning pos0=0x12345, pos3=0x1FFFFF, din=0xA55A, trailer 0x14 → after `done`: same values on outputs, sync_err=0, exactly 168 SCK rises.
- TX decode: vel2=0xBEEF, dout_cmd=0x3A5, wdt_en=1, spol=1, dirtime=3, tap=2, steptime=9 → monitor captures b4=0xEF, b5=0xBE, b8=0xA5, b9=0x43, b10=0x83, b11=0x89.
- Trailer corruption: slave returns b20=0x13 → sync_err=1 on `done`; next frame with 0x14 clears it.
- Timing (CLKDIV=8): `start` at cycle 0 → SSEL falls at cycle 1, first SCK rise at 9, SSEL rises and `done` at 2705, busy=0 at 2713; `start` at 100 ignored.
- Reset at cycle 1000 mid-frame → SSEL=1 at 1001 and pos/din cleared; a new `start` then runs a full correct frame.
